mipi_lane_byte_tx: RTL and testbench

MIPI_LANE_BYTE_TX -- requirements
Module: mipi_lane_byte_tx

---
 rtl/mipi_lane_byte_tx.sv | 134 +++++++++++++
 tb/tb_mipi_lane_byte_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mipi_lane_byte_tx.sv
// MIPI HS lane byte framer: HS-zero preamble, 0xB8 sync, payload, trailer, one GAP cycle.
// Latency: a byte transferred in cycle c is on byte_o in cycle c+1; all outputs except data_ready_o are registered.
// Backpressure: data_ready_o is high in SYNC and in DATA until the last byte is taken; a missing byte truncates the packet.
//
// Ports:
//   clk_i, reset_i         byte clock; synchronous active-low reset
//   data_i / data_valid_i / data_last_i / data_ready_o   payload stream
//   byte_o, hs_active_o    lane byte (LSB first on the wire) and HS-mode flag
//   underrun_o             one-cycle pulse when payload runs dry mid-packet
//   pkt_count_o            16-bit count of framed packets (only with MIPI_TX_PKT_COUNT_EN)
//
// Optional feature macro: MIPI_TX_PKT_COUNT_EN
module mipi_lane_byte_tx #(
  parameter int HS_ZERO_BYTES = 4,
  parameter int TRAILER_BYTES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  input  logic        data_last_i,
  output logic        data_ready_o,
  output logic [7:0]  byte_o,
  output logic        hs_active_o,
  output logic        underrun_o
`ifdef MIPI_TX_PKT_COUNT_EN
  ,
  output logic [15:0] pkt_count_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    HS_ZERO,
    SYNC,
    DATA,
    TRAILER,
    GAP
  } state_t;

  localparam logic [3:0] HS_LAST   = 4'(HS_ZERO_BYTES - 1);
  localparam logic [3:0] TR_LAST   = 4'(TRAILER_BYTES - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  state_t     state;
  logic [3:0] cnt;
  // bit 7 of the most recent sync/data byte put on the lane
  logic       last_bit;
  // set once the last payload byte has been taken; DATA then shows that byte
  // for its cycle with ready low before moving on to the trailer
  logic       last_done;
  logic       xfer;

  assign data_ready_o = (state == SYNC) || ((state == DATA) && !last_done);
  assign xfer         = data_valid_i && data_ready_o;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      last_bit    <= 1'b0;
      last_done   <= 1'b0;
      byte_o      <= 8'h00;
      hs_active_o <= 1'b0;
      underrun_o  <= 1'b0;
`ifdef MIPI_TX_PKT_COUNT_EN
      pkt_count_o <= 16'd0;
`endif
    end else begin
      underrun_o <= 1'b0;
      case (state)
        IDLE: begin
          // the byte that wakes us is left on data_i for SYNC to take
          if (data_valid_i) begin
            state       <= HS_ZERO;
            cnt         <= 4'd0;
            byte_o      <= 8'h00;
            hs_active_o <= 1'b1;
          end
        end
        HS_ZERO: begin
          if (cnt == HS_LAST) begin
            state    <= SYNC;
            cnt      <= 4'd0;
            byte_o   <= SYNC_BYTE;
            last_bit <= SYNC_BYTE[7];
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SYNC, DATA: begin
          if (xfer) begin
            state     <= DATA;
            byte_o    <= data_i;
            last_bit  <= data_i[7];
            last_done <= data_last_i;
          end else begin
            // either the last byte has already gone out, or we starved;
            // both close the packet with the trailer
            state      <= TRAILER;
            cnt        <= 4'd0;
            byte_o     <= {8{~last_bit}};
            last_done  <= 1'b0;
            underrun_o <= data_ready_o;
          end
        end
        TRAILER: begin
          if (cnt == TR_LAST) begin
            state       <= GAP;
            cnt         <= 4'd0;
            byte_o      <= 8'h00;
            hs_active_o <= 1'b0;
`ifdef MIPI_TX_PKT_COUNT_EN
            pkt_count_o <= pkt_count_o + 16'd1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
        default: begin
          state       <= IDLE;
          cnt         <= 4'd0;
          byte_o      <= 8'h00;
          hs_active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_lane_byte_tx.sv
module tb_mipi_lane_byte_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // default-parameter instance
  logic [7:0]  a_data;
  logic        a_valid, a_last, a_ready, a_hs, a_un;
  logic [7:0]  a_byte;
  // HS_ZERO_BYTES=1, TRAILER_BYTES=1 instance
  logic [7:0]  b_data;
  logic        b_valid, b_last, b_ready, b_hs, b_un;
  logic [7:0]  b_byte;
`ifdef MIPI_TX_PKT_COUNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mipi_lane_byte_tx dut_a (
    .clk_i        (clk),
    .reset_i      (rst_n),
    .data_i       (a_data),
    .data_valid_i (a_valid),
    .data_last_i  (a_last),
    .data_ready_o (a_ready),
    .byte_o       (a_byte),
    .hs_active_o  (a_hs),
    .underrun_o   (a_un)
`ifdef MIPI_TX_PKT_COUNT_EN
    ,
    .pkt_count_o  (a_cnt)
`endif
  );

  mipi_lane_byte_tx #(.HS_ZERO_BYTES(1), .TRAILER_BYTES(1)) dut_b (
    .clk_i        (clk),
    .reset_i      (rst_n),
    .data_i       (b_data),
    .data_valid_i (b_valid),
    .data_last_i  (b_last),
    .data_ready_o (b_ready),
    .byte_o       (b_byte),
    .hs_active_o  (b_hs),
    .underrun_o   (b_un)
`ifdef MIPI_TX_PKT_COUNT_EN
    ,
    .pkt_count_o  (b_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one clock, then check every output of instance A
  task automatic cyc_a(input string tag, input logic [7:0] b, input logic hs,
                       input logic rdy, input logic un);
    @(posedge clk); #1;
    chk({tag, ".byte"}, {8'h00, a_byte}, {8'h00, b});
    chk({tag, ".hs"},   {15'd0, a_hs},   {15'd0, hs});
    chk({tag, ".rdy"},  {15'd0, a_ready}, {15'd0, rdy});
    chk({tag, ".un"},   {15'd0, a_un},   {15'd0, un});
  endtask

  task automatic cyc_b(input string tag, input logic [7:0] b, input logic hs,
                       input logic rdy, input logic un);
    @(posedge clk); #1;
    chk({tag, ".byte"}, {8'h00, b_byte}, {8'h00, b});
    chk({tag, ".hs"},   {15'd0, b_hs},   {15'd0, hs});
    chk({tag, ".rdy"},  {15'd0, b_ready}, {15'd0, rdy});
    chk({tag, ".un"},   {15'd0, b_un},   {15'd0, un});
  endtask

  // four HS-zero bytes on instance A
  task automatic hs_zero_a(input string tag);
    for (int i = 0; i < 4; i++) cyc_a({tag, ".hz"}, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  // closing GAP then IDLE cycle on instance A
  task automatic gap_idle_a(input string tag);
    cyc_a({tag, ".gap"},  8'h00, 1'b0, 1'b0, 1'b0);
    cyc_a({tag, ".idle"}, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_data = 8'h00; a_valid = 1'b0; a_last = 1'b0;
    b_data = 8'h00; b_valid = 1'b0; b_last = 1'b0;

    // ---- reset state
    cyc_a("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc_b("rst_b", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef MIPI_TX_PKT_COUNT_EN
    chk("rst.cnt", a_cnt, 16'd0);
`endif
    rst_n = 1'b1;
    cyc_a("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // ---- 3-byte packet 11 22 A3, valid held high; A3 bit7=1 -> trailer 00
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0;
    hs_zero_a("p3");
    cyc_a("p3.sync", 8'hB8, 1'b1, 1'b1, 1'b0);
    cyc_a("p3.d0", 8'h11, 1'b1, 1'b1, 1'b0);
    a_data = 8'h22;
    cyc_a("p3.d1", 8'h22, 1'b1, 1'b1, 1'b0);
    a_data = 8'hA3; a_last = 1'b1;
    cyc_a("p3.d2", 8'hA3, 1'b1, 1'b0, 1'b0);
    a_valid = 1'b0; a_last = 1'b0;
    cyc_a("p3.tr0", 8'h00, 1'b1, 1'b0, 1'b0);
    cyc_a("p3.tr1", 8'h00, 1'b1, 1'b0, 1'b0);
    gap_idle_a("p3");

    // ---- single-byte packet 05; ready high only in SYNC; trailer FF FF
    a_valid = 1'b1; a_data = 8'h05; a_last = 1'b1;
    hs_zero_a("p1");
    cyc_a("p1.sync", 8'hB8, 1'b1, 1'b1, 1'b0);
    cyc_a("p1.d0", 8'h05, 1'b1, 1'b0, 1'b0);
    a_valid = 1'b0; a_last = 1'b0;
    cyc_a("p1.tr0", 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc_a("p1.tr1", 8'hFF, 1'b1, 1'b0, 1'b0);
    gap_idle_a("p1");

    // ---- underrun: 40 41 then valid drops before last
    a_valid = 1'b1; a_data = 8'h40; a_last = 1'b0;
    hs_zero_a("ur");
    cyc_a("ur.sync", 8'hB8, 1'b1, 1'b1, 1'b0);
    cyc_a("ur.d0", 8'h40, 1'b1, 1'b1, 1'b0);
    a_data = 8'h41;
    cyc_a("ur.d1", 8'h41, 1'b1, 1'b1, 1'b0);
    a_valid = 1'b0;
    cyc_a("ur.tr0", 8'hFF, 1'b1, 1'b0, 1'b1);
    cyc_a("ur.tr1", 8'hFF, 1'b1, 1'b0, 1'b0);
    gap_idle_a("ur");
`ifdef MIPI_TX_PKT_COUNT_EN
    chk("ur.cnt", a_cnt, 16'd3);
`endif

    // ---- reset while the 2nd data byte is on the lane
    a_valid = 1'b1; a_data = 8'h12; a_last = 1'b0;
    hs_zero_a("rs");
    cyc_a("rs.sync", 8'hB8, 1'b1, 1'b1, 1'b0);
    cyc_a("rs.d0", 8'h12, 1'b1, 1'b1, 1'b0);
    a_data = 8'h34;
    cyc_a("rs.d1", 8'h34, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc_a("rs.abort", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef MIPI_TX_PKT_COUNT_EN
    chk("rs.cnt", a_cnt, 16'd0);
`endif
    // release with a fresh single-byte packet 07 waiting
    rst_n = 1'b1; a_data = 8'h07; a_last = 1'b1;
    hs_zero_a("rs2");
    cyc_a("rs2.sync", 8'hB8, 1'b1, 1'b1, 1'b0);
    cyc_a("rs2.d0", 8'h07, 1'b1, 1'b0, 1'b0);
    a_valid = 1'b0; a_last = 1'b0;
    cyc_a("rs2.tr0", 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc_a("rs2.tr1", 8'hFF, 1'b1, 1'b0, 1'b0);
    gap_idle_a("rs2");

    // ---- back-to-back packets (81 02) then (7F), valid never drops
    rst_n = 1'b0;
    cyc_a("bb.rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = 8'h81; a_last = 1'b0;
    hs_zero_a("bb0");
    cyc_a("bb0.sync", 8'hB8, 1'b1, 1'b1, 1'b0);
    cyc_a("bb0.d0", 8'h81, 1'b1, 1'b1, 1'b0);
    a_data = 8'h02; a_last = 1'b1;
    cyc_a("bb0.d1", 8'h02, 1'b1, 1'b0, 1'b0);
    a_data = 8'h7F;
    cyc_a("bb0.tr0", 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc_a("bb0.tr1", 8'hFF, 1'b1, 1'b0, 1'b0);
    gap_idle_a("bb0");
    hs_zero_a("bb1");
    cyc_a("bb1.sync", 8'hB8, 1'b1, 1'b1, 1'b0);
    cyc_a("bb1.d0", 8'h7F, 1'b1, 1'b0, 1'b0);
    a_valid = 1'b0; a_last = 1'b0;
    cyc_a("bb1.tr0", 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc_a("bb1.tr1", 8'hFF, 1'b1, 1'b0, 1'b0);
    gap_idle_a("bb1");
`ifdef MIPI_TX_PKT_COUNT_EN
    chk("bb.cnt", a_cnt, 16'd2);
`endif

    // ---- minimal framing: 1 zero byte, 1 trailer byte; payload 90 -> trailer 00
    b_valid = 1'b1; b_data = 8'h90; b_last = 1'b1;
    cyc_b("mb.hz", 8'h00, 1'b1, 1'b0, 1'b0);
    cyc_b("mb.sync", 8'hB8, 1'b1, 1'b1, 1'b0);
    cyc_b("mb.d0", 8'h90, 1'b1, 1'b0, 1'b0);
    b_valid = 1'b0; b_last = 1'b0;
    cyc_b("mb.tr0", 8'h00, 1'b1, 1'b0, 1'b0);
    cyc_b("mb.gap", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc_b("mb.idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // ---- underrun in SYNC: trailer follows B8, so it is ~1 -> 00
    b_valid = 1'b1; b_data = 8'h55; b_last = 1'b0;
    cyc_b("ms.hz", 8'h00, 1'b1, 1'b0, 1'b0);
    b_valid = 1'b0;
    cyc_b("ms.sync", 8'hB8, 1'b1, 1'b1, 1'b0);
    cyc_b("ms.tr0", 8'h00, 1'b1, 1'b0, 1'b1);
    cyc_b("ms.gap", 8'h00, 1'b0, 1'b0, 1'b0);
    cyc_b("ms.idle", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef MIPI_TX_PKT_COUNT_EN
    chk("ms.cnt", b_cnt, 16'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
